// File: rtl/if_scratch_reader.sv
// if_scratch_reader: read-side controller for the input-feature scratchpad.
// Walks the circular scratchpad in sliding-window order, issues reads with a
// fixed one-cycle return latency, buffers the returned cells in a 2-entry
// FIFO and streams them out over valid/ready with a per-window last flag.
// Optional stall counter port is enabled by defining IF_READER_STALL_CNT_EN.
module if_scratch_reader #(
  parameter int SCRATCH_WIDTH        = 8,
  parameter int SCRATCH_ADDRESS_SIZE = 8,
  parameter int CELL_NUMS            = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [SCRATCH_ADDRESS_SIZE-1:0] base_addr,
  input  logic [SCRATCH_ADDRESS_SIZE-1:0] filter_size,
  input  logic [SCRATCH_ADDRESS_SIZE-1:0] stride,
  input  logic [15:0]                     num_windows,
  output logic                            read_en,
  output logic [SCRATCH_ADDRESS_SIZE-1:0] read_addr,
  input  logic [SCRATCH_WIDTH-1:0]        data_out,
  output logic [SCRATCH_WIDTH-1:0]        out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            err
`ifdef IF_READER_STALL_CNT_EN
  ,
  output logic [15:0]                     stall_cnt
`endif
);

  localparam int AW = SCRATCH_ADDRESS_SIZE;
  localparam int SW = SCRATCH_WIDTH;
  localparam logic [AW:0] CELLS = (AW+1)'(CELL_NUMS);
  // Enough compare-and-subtract steps to bring any AW-bit stride below CELL_NUMS.
  localparam int RED_STEPS = (1 << AW) / CELL_NUMS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Job parameters latched at an accepted start
  logic [AW-1:0] f_reg;
  logic [AW-1:0] s_reg;   // stride already folded below CELL_NUMS
  logic [15:0]   w_reg;

  // Walk position: element j of window k, running address and window start
  logic [15:0]   j_reg, k_reg;
  logic [AW-1:0] addr_reg, win_reg;

  // Return path
  logic          rd_pend_reg, last_pend_reg;
  logic          wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    count_reg;
  logic          err_reg;

  // Single compare-and-subtract wrap; operand is always < 2*CELL_NUMS
  function automatic logic [AW-1:0] wrap_addr(input logic [AW:0] a);
    logic [AW:0] r;
    r = (a >= CELLS) ? (a - CELLS) : a;
    return r[AW-1:0];
  endfunction

  // Fold a raw stride below CELL_NUMS so window advance needs one subtract
  function automatic logic [AW-1:0] reduce_stride(input logic [AW-1:0] s);
    logic [AW:0] r;
    r = {1'b0, s};
    for (int i = 0; i < RED_STEPS; i++) begin
      if (r >= CELLS) r = r - CELLS;
    end
    return r[AW-1:0];
  endfunction

  logic          start_bad, accept, pop, credit_ok, drain_done;
  logic [2:0]    occ_after;
  logic [AW-1:0] src_addr, src_win, src_s;
  logic [15:0]   src_j, src_k, src_f_m1, src_w_m1;
  logic          issue, issue_last, issue_final;
  logic [15:0]   j_next, k_next;
  logic [AW-1:0] win_next, addr_next;

  // Start validation and FIFO credit accounting
  always_comb begin
    start_bad  = (filter_size == '0) || ({1'b0, filter_size} > CELLS) ||
                 (stride == '0) || (num_windows == 16'd0) ||
                 ({1'b0, base_addr} >= CELLS);
    accept     = (state_reg == IDLE) && start && !start_bad && !rst;
    pop        = out_valid && out_ready;
    occ_after  = 3'(count_reg) + 3'(rd_pend_reg) - 3'(pop);
    credit_ok  = (occ_after < 3'd2);
    drain_done = (count_reg == 2'd0) && !rd_pend_reg;
  end

  // Walk position source: fresh job values in IDLE, live registers otherwise.
  // The first read is issued in the same cycle the start is accepted.
  always_comb begin
    if (state_reg == IDLE) begin
      src_addr = base_addr;
      src_win  = base_addr;
      src_j    = 16'd0;
      src_k    = 16'd0;
      src_f_m1 = 16'(filter_size) - 16'd1;
      src_w_m1 = num_windows - 16'd1;
      src_s    = reduce_stride(stride);
    end else begin
      src_addr = addr_reg;
      src_win  = win_reg;
      src_j    = j_reg;
      src_k    = k_reg;
      src_f_m1 = 16'(f_reg) - 16'd1;
      src_w_m1 = w_reg - 16'd1;
      src_s    = s_reg;
    end
  end

  // Read issue decision and the walk position after this read
  always_comb begin
    issue_last  = (src_j == src_f_m1);
    issue_final = issue_last && (src_k == src_w_m1);
    issue       = 1'b0;
    unique case (state_reg)
      IDLE:    issue = accept;
      RUN:     issue = credit_ok && !rst;
      default: issue = 1'b0;
    endcase
    if (issue_last) begin
      j_next    = 16'd0;
      k_next    = src_k + 16'd1;
      win_next  = wrap_addr({1'b0, src_win} + {1'b0, src_s});
      addr_next = win_next;
    end else begin
      j_next    = src_j + 16'd1;
      k_next    = src_k;
      win_next  = src_win;
      addr_next = wrap_addr({1'b0, src_addr} + (AW+1)'(1));
    end
  end

  // Next-state logic for IDLE -> RUN -> DRAIN -> IDLE
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = issue_final ? DRAIN : RUN;
      RUN:     if (issue && issue_final) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Job parameters, walk counters and addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      f_reg    <= '0;
      s_reg    <= '0;
      w_reg    <= '0;
      j_reg    <= '0;
      k_reg    <= '0;
      addr_reg <= '0;
      win_reg  <= '0;
    end else begin
      if (accept) begin
        f_reg <= filter_size;
        s_reg <= src_s;
        w_reg <= num_windows;
      end
      if (issue) begin
        j_reg    <= j_next;
        k_reg    <= k_next;
        addr_reg <= addr_next;
        win_reg  <= win_next;
      end
    end
  end

  // In-flight tracking, FIFO pointers/occupancy and the reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_reg   <= 1'b0;
      last_pend_reg <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      err_reg       <= 1'b0;
    end else begin
      rd_pend_reg   <= issue;
      last_pend_reg <= issue_last;
      if (rd_pend_reg) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)         rd_ptr_reg <= ~rd_ptr_reg;
      count_reg     <= count_reg + 2'(rd_pend_reg) - 2'(pop);
      err_reg       <= (state_reg == IDLE) && start && start_bad;
    end
  end

  // FIFO storage: each entry captures the returned cell and its last flag
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [SW-1:0] data_reg;
      logic          last_reg;
      // Capture returned data into this slot when the write pointer selects it
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
          last_reg <= 1'b0;
        end else if (rd_pend_reg && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= data_out;
          last_reg <= last_pend_reg;
        end
      end
    end
  endgenerate

  // Output drive; head entry stays put until popped, so stalls hold the data
  always_comb begin
    out_valid = (count_reg != 2'd0);
    out_data  = rd_ptr_reg ? g_fifo[1].data_reg : g_fifo[0].data_reg;
    out_last  = out_valid && (rd_ptr_reg ? g_fifo[1].last_reg : g_fifo[0].last_reg);
    read_en   = issue;
    read_addr = issue ? src_addr : '0;
    busy      = (state_reg != IDLE);
    done      = (state_reg == DRAIN) && drain_done && !rst;
    err       = err_reg;
  end

`ifdef IF_READER_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Saturating count of back-pressured cycles within the current job
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= 16'd0;
    end else if (accept) begin
      stall_cnt_reg <= 16'd0;
    end else if (busy && out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
